ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register.
- Consumes the decoded EX/MEM/WB control groups, operands, immediate, ALU control code and destination register.
- Computes the ALU result in one cycle for base ops, or over N iterative cycles for MUL/DIVU/REMU while stalling upstream.
- Registers everything into the EX/MEM boundary.

Parameters:
- N, 32: datapath width. Also the iteration count for multicycle ops. Must be ≥4.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX holds a live instruction
- flush  in  1  synchronous kill of in-flight and incoming instruction
- ex_ctrl  in  3  {aluop[1:0], alusrc}
- mem_ctrl  in  3  {memread, memwrite, branch}
- wb_ctrl  in  2  {memtoreg, regwrite}
- alu_con  in  4  ALU operation code
- rs1_data  in  N  operand A
- rs2_data  in  N  operand B / store data
- imm  in  N  sign-extended immediate
- rd  in  5  destination register
- stall  out  1  hold ID/EX and earlier stages this cycle
- out_valid  out  1  EX/MEM entry is live
- alu_result  out  N  registered result
- store_data  out  N  registered rs2_data
- rd_out  out  5  registered rd
- mem_ctrl_out  out  3  registered mem_ctrl, zeroed when not valid
- wb_ctrl_out  out  2  registered wb_ctrl, zeroed when not valid
- zero  out  1  registered (result == 0)
- branch_taken  out  1  registered (mem_ctrl[0] & result == 0 & valid)

Behaviour:
- Reset (rst_n low, asynchronous): all registered outputs 0; FSM = IDLE; iteration counter 0. stall = 0 while in reset.
- Operand B = alusrc ? imm : rs2_data.
- Single-cycle codes:
  - 0000 AND; 0001 OR; 0010 ADD (mod 2^N); 0110 SUB (mod 2^N)
  - 0111 SLT (signed, result 1 or 0); 1100 NOR
- Multicycle codes:
  - 1000 MUL: low N bits of the unsigned product, radix-2 shift-add.
  - 1001 DIVU and 1010 REMU: unsigned restoring division.
- Any other code: result 0, single-cycle.
- FSM states IDLE, BUSY, DONE:
  - IDLE, in_valid, single-cycle op:
    - stall = 0.
    - Next edge: outputs ← result and inputs; out_valid ← 1. Latency 1.
  - IDLE, in_valid, multicycle op:
    - stall = 1 (combinational).
    - Next edge: latch operand A, operand B, op, rd, rs2_data and ctrl groups; counter ← 0; state → BUSY; out_valid ← 0 (bubble, ctrl outputs 0).
  - IDLE, !in_valid: next edge out_valid ← 0; ctrl outputs ← 0; data outputs don't-care.
  - BUSY:
    - stall = 1.
    - One iteration per edge; counter increments.
    - At the edge where counter == N−1: state → DONE. out_valid stays 0.
  - DONE:
    - stall = 0; ID/EX advances on this edge.
    - Next edge: outputs ← latched result and latched ctrl; out_valid ← 1; state → IDLE.
    - The held in_* values are ignored in DONE.
- Multicycle totals: stall high for N+1 cycles; result visible N+2 edges after the op is first presented.
- Divide by zero: completes in the normal N iterations. DIVU = all ones; REMU = dividend.
- flush (highest priority after reset):
  - Next edge: out_valid ← 0; ctrl outputs ← 0; state → IDLE; counter ← 0. Any multicycle op is aborted.
  - stall = 0 in any cycle where flush = 1.
- zero and branch_taken always reflect the value written into alu_result. Both are 0 when out_valid = 0.
- Back-to-back: a single-cycle op presented in DONE's following cycle proceeds normally with no extra bubble.

Test Plan:
- Reset mid-BUSY: assert rst_n = 0 during MUL iteration 5 -> all outputs 0 immediately; stall = 0; after release an ADD 3+4 gives alu_result = 7, out_valid = 1 one edge later.
- Single-cycle ops, alusrc = 1, imm = −1, rs1 = 5:
  - ADD -> 4.
  - SLT with rs1 = −2 (alusrc = 0, rs2 = 1) -> 1.
  - SUB 9−9 with branch = 1 -> zero = 1, branch_taken = 1.
- MUL 0x0001_0003 × 0x0000_0010 -> stall high exactly 33 cycles (N = 32); out_valid rises on edge 34 with result 0x0010_0030; a bubble (out_valid = 0, wb_ctrl_out = 0) is visible in between.
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU x/0 -> 0xFFFF_FFFF; REMU 100/0 -> 100. All with 33 stall cycles.
- flush asserted during BUSY cycle 10 of DIVU -> stall drops that cycle; next edge out_valid = 0; FSM in IDLE; following ADD completes in 1 cycle.
- in_valid = 0 bubble with mem_ctrl = 3'b010 on the inputs -> mem_ctrl_out = 0 and out_valid = 0; no write is ever signalled downstream.

Source files
------------

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage : pipeline execute stage between the ID/EX and EX/MEM registers.
//
// Base ALU ops (AND, OR, ADD, SUB, SLT, NOR) take one cycle. MUL, DIVU and
// REMU run iteratively for N cycles and hold the upstream stages with stall.
// All results and the forwarded control groups are registered into EX/MEM.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid, flush   live instruction in ID/EX / kill in-flight + incoming
//   ex_ctrl           {aluop[1:0], alusrc}; only alusrc is used here
//   mem_ctrl, wb_ctrl control groups forwarded to MEM / WB
//   alu_con           ALU operation code
//   rs1_data, rs2_data, imm, rd   operands, immediate, destination register
//   stall             hold ID/EX and earlier stages this cycle
//   out_valid, alu_result, store_data, rd_out, mem_ctrl_out, wb_ctrl_out,
//   zero, branch_taken  registered EX/MEM outputs
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic         flush,
    input  logic [2:0]   ex_ctrl,
    input  logic [2:0]   mem_ctrl,
    input  logic [1:0]   wb_ctrl,
    input  logic [3:0]   alu_con,
    input  logic [N-1:0] rs1_data,
    input  logic [N-1:0] rs2_data,
    input  logic [N-1:0] imm,
    input  logic [4:0]   rd,
    output logic         stall,
    output logic         out_valid,
    output logic [N-1:0] alu_result,
    output logic [N-1:0] store_data,
    output logic [4:0]   rd_out,
    output logic [2:0]   mem_ctrl_out,
    output logic [1:0]   wb_ctrl_out,
    output logic         zero,
    output logic         branch_taken
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;

    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    // a_reg: multiplier (shifts right) or dividend/quotient (shifts left)
    // b_reg: multiplicand (shifts left) or divisor (constant)
    // p_reg: product accumulator or partial remainder
    logic [N-1:0]       a_reg;
    logic [N-1:0]       b_reg;
    logic [N-1:0]       p_reg;
    logic [N-1:0]       st_reg;
    logic [3:0]         op_reg;
    logic [4:0]         rd_reg;
    logic [2:0]         mem_reg;
    logic [1:0]         wb_reg;

    logic [N-1:0]       op_b;
    logic               is_multi;
    logic [N-1:0]       alu_comb;
    logic [N-1:0]       multi_res;
    logic [N:0]         div_shift;
    logic [N:0]         div_trial;

    // aluop is decoded upstream into alu_con; it is carried but not consumed
    logic               unused_aluop;
    assign unused_aluop = ^ex_ctrl[2:1];

    assign op_b     = ex_ctrl[0] ? imm : rs2_data;
    assign is_multi = (alu_con == OP_MUL) || (alu_con == OP_DIVU) ||
                      (alu_con == OP_REMU);

    always_comb begin
        alu_comb = '0;
        case (alu_con)
            OP_AND:  alu_comb = rs1_data & op_b;
            OP_OR:   alu_comb = rs1_data | op_b;
            OP_ADD:  alu_comb = rs1_data + op_b;
            OP_SUB:  alu_comb = rs1_data - op_b;
            OP_SLT:  alu_comb = {{(N-1){1'b0}}, ($signed(rs1_data) < $signed(op_b))};
            OP_NOR:  alu_comb = ~(rs1_data | op_b);
            default: alu_comb = '0;
        endcase
    end

    // Restoring division step: shift next dividend bit into the remainder and
    // try subtracting the divisor; a borrow (MSB set) means restore.
    // With a zero divisor the trial never borrows, giving an all-ones
    // quotient and the dividend as remainder.
    assign div_shift = {p_reg, a_reg[N-1]};
    assign div_trial = div_shift - {1'b0, b_reg};

    assign multi_res = (op_reg == OP_DIVU) ? a_reg : p_reg;

    // No stall while in reset or while a flush is killing the pipe
    assign stall = rst_n && !flush &&
                   (((state_reg == IDLE) && in_valid && is_multi) ||
                    (state_reg == BUSY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            p_reg        <= '0;
            st_reg       <= '0;
            op_reg       <= '0;
            rd_reg       <= '0;
            mem_reg      <= '0;
            wb_reg       <= '0;
            out_valid    <= 1'b0;
            alu_result   <= '0;
            store_data   <= '0;
            rd_out       <= '0;
            mem_ctrl_out <= '0;
            wb_ctrl_out  <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
        end else if (flush) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            out_valid    <= 1'b0;
            mem_ctrl_out <= '0;
            wb_ctrl_out  <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && is_multi) begin
                        a_reg        <= rs1_data;
                        b_reg        <= op_b;
                        p_reg        <= '0;
                        st_reg       <= rs2_data;
                        op_reg       <= alu_con;
                        rd_reg       <= rd;
                        mem_reg      <= mem_ctrl;
                        wb_reg       <= wb_ctrl;
                        cnt_reg      <= '0;
                        state_reg    <= BUSY;
                        out_valid    <= 1'b0;
                        mem_ctrl_out <= '0;
                        wb_ctrl_out  <= '0;
                        zero         <= 1'b0;
                        branch_taken <= 1'b0;
                    end else if (in_valid) begin
                        out_valid    <= 1'b1;
                        alu_result   <= alu_comb;
                        store_data   <= rs2_data;
                        rd_out       <= rd;
                        mem_ctrl_out <= mem_ctrl;
                        wb_ctrl_out  <= wb_ctrl;
                        zero         <= (alu_comb == '0);
                        branch_taken <= mem_ctrl[0] && (alu_comb == '0);
                    end else begin
                        out_valid    <= 1'b0;
                        mem_ctrl_out <= '0;
                        wb_ctrl_out  <= '0;
                        zero         <= 1'b0;
                        branch_taken <= 1'b0;
                    end
                end
                BUSY: begin
                    if (op_reg == OP_MUL) begin
                        if (a_reg[0]) begin
                            p_reg <= p_reg + b_reg;
                        end
                        a_reg <= a_reg >> 1;
                        b_reg <= b_reg << 1;
                    end else begin
                        p_reg <= div_trial[N] ? div_shift[N-1:0] : div_trial[N-1:0];
                        a_reg <= {a_reg[N-2:0], ~div_trial[N]};
                    end
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(N-1)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    out_valid    <= 1'b1;
                    alu_result   <= multi_res;
                    store_data   <= st_reg;
                    rd_out       <= rd_reg;
                    mem_ctrl_out <= mem_reg;
                    wb_ctrl_out  <= wb_reg;
                    zero         <= (multi_res == '0);
                    branch_taken <= mem_reg[0] && (multi_res == '0);
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage : directed self-checking bench for ex_stage (N = 32).
// -----------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        flush;
    logic [2:0]  ex_ctrl;
    logic [2:0]  mem_ctrl;
    logic [1:0]  wb_ctrl;
    logic [3:0]  alu_con;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        stall;
    logic        out_valid;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [4:0]  rd_out;
    logic [2:0]  mem_ctrl_out;
    logic [1:0]  wb_ctrl_out;
    logic        zero;
    logic        branch_taken;

    int checks = 0;
    int errors = 0;

    ex_stage #(.N(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .flush        (flush),
        .ex_ctrl      (ex_ctrl),
        .mem_ctrl     (mem_ctrl),
        .wb_ctrl      (wb_ctrl),
        .alu_con      (alu_con),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .imm          (imm),
        .rd           (rd),
        .stall        (stall),
        .out_valid    (out_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_out       (rd_out),
        .mem_ctrl_out (mem_ctrl_out),
        .wb_ctrl_out  (wb_ctrl_out),
        .zero         (zero),
        .branch_taken (branch_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic src, input logic [2:0] mc,
                         input logic [1:0] wc, input logic [4:0] r);
        in_valid = 1'b1;
        alu_con  = op;
        rs1_data = a;
        rs2_data = b;
        imm      = im;
        ex_ctrl  = {2'b10, src};
        mem_ctrl = mc;
        wb_ctrl  = wc;
        rd       = r;
    endtask

    task automatic run_single(input string tag, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im, input logic src,
                              input logic [31:0] exp);
        drive(op, a, b, im, src, 3'b000, 2'b01, 5'd3);
        #1;
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, alu_result, exp);
        $display("single %s a=%h b=%h imm=%h src=%0d -> %h", tag, a, b, im, src, alu_result);
    endtask

    task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int stalls = 0;
        int edges  = 0;
        int bubble_bad = 0;
        drive(op, a, b, 32'd0, 1'b0, 3'b000, 2'b01, 5'd9);
        #1;
        while (stall && stalls < 100) begin
            stalls++;
            tick();
            edges++;
            if (out_valid !== 1'b0 || wb_ctrl_out !== 2'b00) bubble_bad++;
        end
        check({tag, "_stall_cycles"}, stalls, 32'd33);
        check({tag, "_bubble"}, bubble_bad, 32'd0);
        tick();
        edges++;
        in_valid = 1'b0;
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_result"}, alu_result, exp);
        check({tag, "_rd"}, {27'd0, rd_out}, 32'd9);
        check({tag, "_store"}, store_data, b);
        $display("multi %s a=%h b=%h stalls=%0d edges=%0d -> %h", tag, a, b, stalls, edges, alu_result);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        ex_ctrl  = '0;
        mem_ctrl = '0;
        wb_ctrl  = '0;
        alu_con  = '0;
        rs1_data = '0;
        rs2_data = '0;
        imm      = '0;
        rd       = '0;

        // Reset state
        #1;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", alu_result, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        $display("reset released");

        // Single-cycle ops
        run_single("add_imm", 4'b0010, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'd4);
        run_single("slt", 4'b0111, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b0, 32'd1);
        run_single("slt_false", 4'b0111, 32'd1, 32'hFFFF_FFFE, 32'd0, 1'b0, 32'd0);
        run_single("or", 4'b0001, 32'h0000_00F0, 32'h0000_000F, 32'd0, 1'b0, 32'h0000_00FF);
        run_single("and", 4'b0000, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 1'b0, 32'h0F00_0F00);
        run_single("nor", 4'b1100, 32'h0000_0000, 32'h0000_FFFF, 32'd0, 1'b0, 32'hFFFF_0000);
        run_single("undef", 4'b0011, 32'd7, 32'd8, 32'd0, 1'b0, 32'd0);

        // SUB 9-9 with branch
        drive(4'b0110, 32'd9, 32'd9, 32'd0, 1'b0, 3'b001, 2'b00, 5'd4);
        tick();
        in_valid = 1'b0;
        check("sub_result", alu_result, 32'd0);
        check("sub_zero", {31'd0, zero}, 32'd1);
        check("sub_branch", {31'd0, branch_taken}, 32'd1);
        check("sub_memctrl", {29'd0, mem_ctrl_out}, 32'd1);
        $display("single sub 9-9 -> %h zero=%0d taken=%0d", alu_result, zero, branch_taken);

        // Multicycle ops
        run_multi("mul", 4'b1000, 32'h0001_0003, 32'h0000_0010, 32'h0010_0030);
        run_multi("divu", 4'b1001, 32'd100, 32'd7, 32'd14);
        run_multi("remu", 4'b1010, 32'd100, 32'd7, 32'd2);
        run_multi("divu_zero", 4'b1001, 32'h0000_DEAD, 32'd0, 32'hFFFF_FFFF);
        run_multi("remu_zero", 4'b1010, 32'd100, 32'd0, 32'd100);

        // Back-to-back: single-cycle op right after a multicycle one
        run_multi("mul_b2b", 4'b1000, 32'd6, 32'd7, 32'd42);
        run_single("add_b2b", 4'b0010, 32'd10, 32'd20, 32'd0, 1'b0, 32'd30);

        // Flush during BUSY cycle 10 of DIVU
        drive(4'b1001, 32'd1000, 32'd3, 32'd0, 1'b0, 3'b000, 2'b01, 5'd2);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", {31'd0, out_valid}, 32'd0);
        check("flush_wb", {30'd0, wb_ctrl_out}, 32'd0);
        $display("flush during divu busy cycle 10 -> out_valid=%0d", out_valid);
        run_single("add_after_flush", 4'b0010, 32'd11, 32'd12, 32'd0, 1'b0, 32'd23);

        // Reset mid-BUSY during MUL iteration 5
        drive(4'b1000, 32'h1234_5678, 32'd3, 32'd0, 1'b0, 3'b000, 2'b01, 5'd1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("rst_busy_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy_result", alu_result, 32'd0);
        check("rst_busy_stall", {31'd0, stall}, 32'd0);
        check("rst_busy_wb", {30'd0, wb_ctrl_out}, 32'd0);
        $display("reset mid-busy -> valid=%0d result=%h stall=%0d", out_valid, alu_result, stall);
        rst_n = 1'b1;
        run_single("add_after_reset", 4'b0010, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7);

        // in_valid=0 bubble with a store pattern on the inputs
        drive(4'b0010, 32'd1, 32'd1, 32'd0, 1'b0, 3'b010, 2'b01, 5'd5);
        in_valid = 1'b0;
        tick();
        check("bubble_valid", {31'd0, out_valid}, 32'd0);
        check("bubble_memctrl", {29'd0, mem_ctrl_out}, 32'd0);
        check("bubble_wb", {30'd0, wb_ctrl_out}, 32'd0);
        $display("bubble mem_ctrl=010 -> mem_ctrl_out=%b valid=%0d", mem_ctrl_out, out_valid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
